// File: rtl/conv2d_kernel.sv
// conv2d_kernel: streaming 3x3 convolution with programmable signed taps,
// arithmetic right shift and signed saturation on a ready/valid pixel stream.
module conv2d_kernel #(
  parameter int linewidth_px_p = 480,
  parameter int lines_p        = 480,
  parameter int width_p        = 8,
  parameter int coeff_width_p  = 4,
  parameter int out_width_p    = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [width_p-1:0]            data_i,
  input  logic [9*coeff_width_p-1:0]    coeff_i,
  input  logic [$clog2(out_width_p+width_p+coeff_width_p+4)-1:0] shift_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic signed [out_width_p-1:0] data_o,
  output logic                          last_o
);

  localparam int sum_w_lp = width_p + coeff_width_p + 5;
  localparam int sh_w_lp  =
    $clog2(out_width_p + width_p + coeff_width_p + 4);
  localparam int col_w_lp = $clog2(linewidth_px_p);
  localparam int row_w_lp = $clog2(lines_p);
  localparam int ext_w_lp = sum_w_lp + out_width_p;

  localparam logic signed [ext_w_lp-1:0] max_lp =
    ext_w_lp'((64'sd1 <<< (out_width_p - 1)) - 64'sd1);
  localparam logic signed [ext_w_lp-1:0] min_lp = ~max_lp;

  logic [col_w_lp-1:0] col_q;
  logic [row_w_lp-1:0] row_q;
  logic                accept;
  logic                col_last;
  logic                row_last;
  logic                frame_first;
  logic                win_ok;

  logic [width_p-1:0] lb0_mem [linewidth_px_p];
  logic [width_p-1:0] lb1_mem [linewidth_px_p];
  logic [width_p-1:0] tap0;
  logic [width_p-1:0] tap1;
  logic [width_p-1:0] win_q [3][2];
  logic [width_p-1:0] win   [9];

  logic signed [coeff_width_p-1:0] coef_q [9];
  logic [sh_w_lp-1:0]              shift_q;

  logic signed [sum_w_lp-1:0]    px_ext [9];
  logic signed [sum_w_lp-1:0]    cf_ext [9];
  logic signed [sum_w_lp-1:0]    sum;
  logic signed [sum_w_lp-1:0]    shifted;
  logic signed [ext_w_lp-1:0]    ext;
  logic signed [out_width_p-1:0] sat;

  assign ready_o     = ~valid_o | ready_i;
  assign accept      = valid_i & ready_o;
  assign col_last    = col_q == col_w_lp'(linewidth_px_p - 1);
  assign row_last    = row_q == row_w_lp'(lines_p - 1);
  assign frame_first = (col_q == '0) && (row_q == '0);
  assign win_ok      = (row_q >= row_w_lp'(2)) &&
                       (col_q >= col_w_lp'(2));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + row_w_lp'(1);
      end else begin
        col_q <= col_q + col_w_lp'(1);
      end
    end
  end

  // Taps are latched once per frame so mid-frame changes cannot tear a frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < 9; i++) coef_q[i] <= '0;
      shift_q <= '0;
    end else if (accept && frame_first) begin
      for (int i = 0; i < 9; i++)
        coef_q[i] <= coeff_i[i*coeff_width_p +: coeff_width_p];
      shift_q <= shift_i;
    end
  end

  assign tap0 = lb0_mem[col_q];
  assign tap1 = lb1_mem[col_q];

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_mem[col_q] <= tap1;
      lb1_mem[col_q] <= data_i;
      win_q[0][0]    <= win_q[0][1];
      win_q[0][1]    <= tap0;
      win_q[1][0]    <= win_q[1][1];
      win_q[1][1]    <= tap1;
      win_q[2][0]    <= win_q[2][1];
      win_q[2][1]    <= data_i;
    end
  end

  always_comb begin
    win[0] = win_q[0][0];
    win[1] = win_q[0][1];
    win[2] = tap0;
    win[3] = win_q[1][0];
    win[4] = win_q[1][1];
    win[5] = tap1;
    win[6] = win_q[2][0];
    win[7] = win_q[2][1];
    win[8] = data_i;
  end

  // Sum width covers nine worst-case products, so no overflow before shift.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      px_ext[i] = {{(sum_w_lp - width_p){1'b0}}, win[i]};
      cf_ext[i] = {{(sum_w_lp - coeff_width_p){coef_q[i][coeff_width_p-1]}},
                   coef_q[i]};
      sum = sum + px_ext[i] * cf_ext[i];
    end
  end

  always_comb begin
    shifted = sum >>> shift_q;
    ext     = {{out_width_p{shifted[sum_w_lp-1]}}, shifted};
    if (ext > max_lp) begin
      sat = max_lp[out_width_p-1:0];
    end else if (ext < min_lp) begin
      sat = min_lp[out_width_p-1:0];
    end else begin
      sat = ext[out_width_p-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else if (ready_o) begin
      valid_o <= accept & win_ok;
      if (accept && win_ok) begin
        data_o <= sat;
        last_o <= row_last & col_last;
      end
    end
  end

endmodule
